// File: rtl/eth_pkg.sv
// Shared Ethernet RX constants, CRC-32 parameters and the framer state enum.
// Imported by eth_crc32 and eth_rx_framer.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          MIN_FRAME     = 64;
  localparam int          MAX_FRAME     = 1522;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  function automatic logic [31:0] bitrev32(logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Combinational reflected CRC-32 byte step, LSB of the byte first.
// Ports: crc_in (current CRC), data (byte), crc_out (updated CRC).
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = bitrev32(CRC32_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_R;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_framer.sv
// RGMII RX framer: strips preamble/SFD, forwards frame bytes with Last/Err.
// Ports: i_Clock/i_Rst_n, i_Rx_Data/i_Rx_Ctl in, i_Full, o_* fifo write, stats.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = MIN_FRAME,
  parameter int MAX_LEN = MAX_FRAME,
  parameter int CNT_W   = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic [7:0]       i_Rx_Data,
  input  logic [1:0]       i_Rx_Ctl,
  input  logic             i_Full,
  output logic [7:0]       o_Data,
  output logic             o_Valid,
  output logic             o_Last,
  output logic             o_Err,
  output logic [CNT_W-1:0] o_Frame_Count,
  output logic [CNT_W-1:0] o_Drop_Count
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_OVR = LEN_W'(MAX_LEN + 1);

  rx_state_e        state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hvld_q, hvld_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [31:0]      crc_q, crc_d, crc_nx;
  logic             rxer_q, rxer_d;
  logic             pend_q, pend_d;

  logic       wr, wr_last, wr_err;
  logic [7:0] wr_data;
  logic       frame_inc, drop_inc;
  logic       dv, rx_er, runt, fcs_bad;

  // DV low with Ctl[1] set is false carrier / extension: just not data.
  assign dv      = i_Rx_Ctl[0];
  assign rx_er   = dv & (i_Rx_Ctl[1] ^ i_Rx_Ctl[0]);
  assign runt    = len_q < LEN_MIN;
  assign fcs_bad = crc_q != CRC32_RESIDUE;
  assign len_inc = (len_q == LEN_OVR) ? len_q : len_q + LEN_W'(1);

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (i_Rx_Data),
    .crc_out (crc_nx)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hvld_d    = hvld_q;
    len_d     = len_q;
    crc_d     = crc_q;
    rxer_d    = rxer_q;
    pend_d    = pend_q;
    wr        = 1'b0;
    wr_data   = 8'h00;
    wr_last   = 1'b0;
    wr_err    = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;

    // Pending terminator never coincides with a PAYLOAD write.
    if (pend_q && !i_Full) begin
      wr      = 1'b1;
      wr_last = 1'b1;
      wr_err  = 1'b1;
      pend_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (dv) begin
          if (i_Rx_Data == ETH_PREAMBLE) begin
            state_d = ST_PREAMBLE;
          end else begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!dv) begin
          state_d = ST_IDLE;
        end else if (i_Rx_Data == ETH_PREAMBLE) begin
          state_d = ST_PREAMBLE;
        end else if (i_Rx_Data == ETH_SFD && !pend_q) begin
          state_d = ST_PAYLOAD;
          len_d   = '0;
          crc_d   = CRC32_INIT;
          rxer_d  = 1'b0;
          hvld_d  = 1'b0;
        end else begin
          state_d  = ST_DROP;
          drop_inc = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (dv) begin
          len_d  = len_inc;
          crc_d  = crc_nx;
          rxer_d = rxer_q | rx_er;
          if (len_inc == LEN_OVR) begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
            hvld_d   = 1'b0;
            if (i_Full) begin
              pend_d = 1'b1;
            end else begin
              wr      = 1'b1;
              wr_data = hold_q;
              wr_last = 1'b1;
              wr_err  = 1'b1;
            end
          end else begin
            hold_d = i_Rx_Data;
            hvld_d = 1'b1;
            if (hvld_q && i_Full) begin
              pend_d   = 1'b1;
              state_d  = ST_DROP;
              drop_inc = 1'b1;
              hvld_d   = 1'b0;
            end else if (hvld_q) begin
              wr      = 1'b1;
              wr_data = hold_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
          hvld_d  = 1'b0;
          if (!hvld_q) begin
            drop_inc = 1'b1;
          end else if (i_Full) begin
            pend_d   = 1'b1;
            drop_inc = 1'b1;
          end else begin
            wr        = 1'b1;
            wr_data   = hold_q;
            wr_last   = 1'b1;
            wr_err    = rxer_q | runt | fcs_bad;
            frame_inc = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hvld_q        <= 1'b0;
      len_q         <= '0;
      crc_q         <= CRC32_INIT;
      rxer_q        <= 1'b0;
      pend_q        <= 1'b0;
      o_Data        <= '0;
      o_Valid       <= 1'b0;
      o_Last        <= 1'b0;
      o_Err         <= 1'b0;
      o_Frame_Count <= '0;
      o_Drop_Count  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hvld_q  <= hvld_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      rxer_q  <= rxer_d;
      pend_q  <= pend_d;
      o_Data  <= wr_data;
      o_Valid <= wr;
      o_Last  <= wr_last;
      o_Err   <= wr_err;
      if (frame_inc && o_Frame_Count != '1)
        o_Frame_Count <= o_Frame_Count + CNT_W'(1);
      if (drop_inc && o_Drop_Count != '1)
        o_Drop_Count <= o_Drop_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Scoreboard bench for eth_rx_framer: expected writes queued at stimulus,
// popped and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_eth_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic [1:0]  rx_ctl;
  logic        full;
  logic [7:0]  data;
  logic        valid, last, err;
  logic [15:0] frames, drops;

  logic [9:0]  q[$];
  logic [7:0]  frm[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  eth_rx_framer dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Data     (rx_data),
    .i_Rx_Ctl      (rx_ctl),
    .i_Full        (full),
    .o_Data        (data),
    .o_Valid       (valid),
    .o_Last        (last),
    .o_Err         (err),
    .o_Frame_Count (frames),
    .o_Drop_Count  (drops)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] d);
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) check("wr_extra", valid, 1'b0);
      else check("wr", {err, last, data}, q.pop_front());
    end
  end

  task automatic drive(logic [7:0] d, logic [1:0] c, logic f);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_ctl  = c;
    full    = f;
  endtask

  task automatic build(int n, bit good);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
    if (!good) frm[n] = frm[n] ^ 8'h01;
  endtask

  task automatic push_frame(int nwr, logic e);
    for (int i = 0; i < nwr; i++)
      q.push_back({(i == nwr - 1) ? e : 1'b0, i == nwr - 1, frm[i]});
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) drive(8'h55, 2'b11, 1'b0);
    drive(8'hD5, 2'b11, 1'b0);
  endtask

  task automatic send(int er_idx, int f_lo, int f_hi);
    preamble();
    for (int i = 0; i < frm.size(); i++)
      drive(frm[i], (i + 1 == er_idx) ? 2'b01 : 2'b11,
            (i + 1 >= f_lo) && (i + 1 <= f_hi));
    for (int i = 0; i < 5; i++) drive(8'h00, 2'b00, 1'b0);
  endtask

  task automatic stats(string tag, int nf, int nd);
    check({tag, "_q"}, q.size(), 0);
    check({tag, "_frames"}, frames, nf);
    check({tag, "_drops"}, drops, nd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_ctl = '0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {err, last, valid, data}, 0);
    stats("rst", 0, 0);
    rst_n = 1'b1;

    build(60, 1'b1); push_frame(64, 1'b0); send(-1, 1, 0);
    stats("good", 1, 0);

    build(60, 1'b0); push_frame(64, 1'b1); send(-1, 1, 0);
    stats("badfcs", 2, 0);

    for (int i = 0; i < 3; i++) drive(8'hAA, 2'b10, 1'b0);
    drive(8'h55, 2'b11, 1'b0);
    drive(8'h55, 2'b11, 1'b0);
    drive(8'hAA, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'h00, 2'b00, 1'b0);
    stats("badpre", 2, 1);

    build(36, 1'b1); push_frame(40, 1'b1); send(-1, 1, 0);
    stats("runt", 3, 1);

    build(96, 1'b1); push_frame(100, 1'b1); send(50, 1, 0);
    stats("rxer", 4, 1);

    build(1596, 1'b1); push_frame(1522, 1'b1); send(-1, 1, 0);
    stats("oversize", 4, 2);

    build(60, 1'b1);
    for (int i = 0; i < 9; i++) q.push_back({2'b00, frm[i]});
    q.push_back(10'h300);
    send(-1, 11, 20);
    stats("full", 4, 3);

    build(60, 1'b1);
    for (int i = 0; i < 18; i++) q.push_back({2'b00, frm[i]});
    preamble();
    for (int i = 0; i < 20; i++) drive(frm[i], 2'b11, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; rx_ctl = 2'b00;
    #1;
    check("midrst_out", {err, last, valid, data}, 0);
    stats("midrst", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    build(60, 1'b1); push_frame(64, 1'b0); send(-1, 1, 0);
    stats("after_rst", 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
